// File: rtl/bram_pkg.sv
// Shared defaults and elaboration helpers for the simple-dual-port buffer.
// Holds no ports. The functions are evaluated during elaboration only.
package bram_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int DEPTH_DEF      = 72;
  localparam int BYTE_SHIFT_DEF = 2;

  // Address width for an n-entry array. Never returns 0, so a 2-entry
  // buffer still gets a legal 1-bit address.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Read latency in cycles, counted from the rd_en edge to rd_valid.
  function automatic int rd_lat(input int out_reg);
    return 1 + out_reg;
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Inferred block-RAM core: one write port and one registered read port.
// A read and a write that hit the same word in one cycle return the old
// contents (read-first).
// Ports:
//   clk      rising-edge clock
//   i_we     write enable (the caller guarantees i_waddr < DEPTH)
//   i_waddr  write word address
//   i_wdata  write data
//   i_re     read enable (the caller guarantees i_raddr < DEPTH)
//   i_raddr  read word address
//   o_rdata  registered read data; holds its value while i_re is low
module bram_sdp_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 72,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset branch. A reset loop over every word
  // would stop the tools from mapping it onto block RAM.
  // NOTE: non-blocking assignments make the read sample r_mem before
  // this edge's write lands, which is exactly the read-first behaviour.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_buffer_sdp.sv
// Simple-dual-port ifmap/weight buffer for the fused-block CNN datapath.
// Write side: explicit address or auto-incrementing load pointer.
// Read side: byte address, range-checked, valid-tagged pipeline.
// Read latency is 1 + OUT_REG cycles.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   wr_en, wr_auto      write strobe; 1 selects the load pointer as the target
//   wr_addr, wr_data    explicit write word address and write data
//   load_clr            clears the load pointer and load_done
//   load_ptr, load_done current auto-write pointer; sticky "filled" flag
//   rd_en, rd_addr      read request and byte address
//   rd_data, rd_valid   response data and its valid tag
//   rd_oor              the response's word index was >= DEPTH
module bram_buffer_sdp
  import bram_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  parameter  int RD_ADDR_W  = 20,
  parameter  int BYTE_SHIFT = BYTE_SHIFT_DEF,
  parameter  int OUT_REG    = 1,
  localparam int WA_W       = clog2_min1(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_auto,
  input  logic [WA_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 load_clr,
  output logic [WA_W-1:0]      load_ptr,
  output logic                 load_done,
  input  logic                 rd_en,
  input  logic [RD_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 rd_oor
);

  logic [WA_W-1:0]      r_load_ptr;
  logic                 r_load_done;
  logic [WA_W-1:0]      w_wr_tgt;
  logic                 w_wr_ok;
  logic [RD_ADDR_W-1:0] w_rd_idx;
  logic                 w_rd_oor;
  logic [DATA_W-1:0]    w_core_q;
  logic                 r_v1;
  logic                 r_zero1;
  logic [DATA_W-1:0]    w_d1;
  logic                 w_oor1;

  // load_clr with an auto write restarts the load at word 0.
  assign w_wr_tgt = wr_auto ? (load_clr ? '0 : r_load_ptr) : wr_addr;
  // The extra bit keeps DEPTH representable when it is a power of two.
  assign w_wr_ok  = wr_en && ({1'b0, w_wr_tgt} < (WA_W+1)'(DEPTH));

  // The full-width index drives the range check, so addresses far
  // beyond the array cannot alias back into it.
  assign w_rd_idx = rd_addr >> BYTE_SHIFT;
  assign w_rd_oor = w_rd_idx >= RD_ADDR_W'(DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_ptr  <= '0;
      r_load_done <= 1'b0;
    end else if (wr_en && wr_auto) begin
      if (load_clr) begin
        r_load_ptr  <= WA_W'(1);
        r_load_done <= 1'b0;
      end else if (r_load_ptr == WA_W'(DEPTH - 1)) begin
        r_load_ptr  <= '0;
        r_load_done <= 1'b1;
      end else begin
        r_load_ptr  <= r_load_ptr + WA_W'(1);
      end
    end else if (load_clr) begin
      r_load_ptr  <= '0;
      r_load_done <= 1'b0;
    end
  end

  assign load_ptr  = r_load_ptr;
  assign load_done = r_load_done;

  bram_sdp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (WA_W)
  ) u_core (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (w_wr_tgt),
    .i_wdata (wr_data),
    .i_re    (rd_en && !w_rd_oor),
    .i_raddr (w_rd_idx[WA_W-1:0]),
    .o_rdata (w_core_q)
  );

  // r_zero1 masks the core output. It is set by an out-of-range
  // response and by reset, and it is updated only when a request
  // arrives. Idle cycles therefore keep showing the last response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_zero1 <= 1'b1;
    end else begin
      r_v1 <= rd_en;
      if (rd_en) r_zero1 <= w_rd_oor;
    end
  end

  assign w_d1   = r_zero1 ? '0 : w_core_q;
  assign w_oor1 = r_v1 & r_zero1;

  if (rd_lat(OUT_REG) == 2) begin : g_out_reg
    logic [DATA_W-1:0] r_d2;
    logic              r_v2;
    logic              r_oor2;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_d2   <= '0;
        r_v2   <= 1'b0;
        r_oor2 <= 1'b0;
      end else begin
        r_v2   <= r_v1;
        r_oor2 <= w_oor1;
        if (r_v1) r_d2 <= w_d1;
      end
    end

    assign rd_data  = r_d2;
    assign rd_valid = r_v2;
    assign rd_oor   = r_oor2;
  end else begin : g_no_out_reg
    assign rd_data  = w_d1;
    assign rd_valid = r_v1;
    assign rd_oor   = w_oor1;
  end

endmodule

// File: tb/tb_bram_buffer_sdp.sv
// Bench for bram_buffer_sdp. One instance is built with OUT_REG=1
// (latency 2) and one with OUT_REG=0 (latency 1), and both see the same
// stimulus. A behavioural model records every request by clock edge. A
// negedge process then checks both instances against it, and literal
// checks in the stimulus pin the model to hand-computed values.
module tb_bram_buffer_sdp;

  localparam int DEPTH = 72;
  localparam int WA_W  = 7;
  localparam int NE    = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, wr_en, wr_auto, load_clr, rd_en;
  logic [WA_W-1:0] wr_addr;
  logic [31:0]     wr_data;
  logic [19:0]     rd_addr;

  logic [WA_W-1:0] ptr1, ptr0;
  logic            done1, done0, v1, v0, o1, o0;
  logic [31:0]     d1, d0;

  bram_buffer_sdp #(.OUT_REG(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_auto(wr_auto),
    .wr_addr(wr_addr), .wr_data(wr_data), .load_clr(load_clr),
    .load_ptr(ptr1), .load_done(done1), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d1), .rd_valid(v1), .rd_oor(o1)
  );

  bram_buffer_sdp #(.OUT_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_auto(wr_auto),
    .wr_addr(wr_addr), .wr_data(wr_data), .load_clr(load_clr),
    .load_ptr(ptr0), .load_done(done0), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d0), .rd_valid(v0), .rd_oor(o0)
  );

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  // Model state. The array index is the clock edge that sampled the inputs.
  logic [31:0] m_mem [DEPTH];
  int          m_ptr = 0;
  bit          m_done = 1'b0;
  bit          rst_at   [NE];
  bit          req_v    [NE];
  bit          req_o    [NE];
  logic [31:0] req_d    [NE];
  int          exp_ptr  [NE];
  bit          exp_done [NE];
  logic [31:0] last_d   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Apply the model rules to the inputs present now, then advance one edge.
  task automatic step();
    int e;
    int idx;
    int tgt;
    e = edge_n + 1;
    rst_at[e] = reset;
    req_v[e]  = 1'b0;
    if (reset) begin
      m_ptr  = 0;
      m_done = 1'b0;
    end else begin
      if (rd_en) begin
        idx = int'(rd_addr) / 4;
        req_v[e] = 1'b1;
        req_o[e] = (idx >= DEPTH);
        req_d[e] = (idx >= DEPTH) ? 32'h0 : m_mem[idx];
      end
      if (wr_en && wr_auto) begin
        tgt = load_clr ? 0 : m_ptr;
        m_mem[tgt] = wr_data;
        if (load_clr) begin
          m_ptr  = 1;
          m_done = 1'b0;
        end else begin
          if (m_ptr == DEPTH - 1) m_done = 1'b1;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end else begin
        if (wr_en && int'(wr_addr) < DEPTH) m_mem[int'(wr_addr)] = wr_data;
        if (load_clr) begin
          m_ptr  = 0;
          m_done = 1'b0;
        end
      end
    end
    exp_ptr[e]  = m_ptr;
    exp_done[e] = m_done;
    @(posedge clk);
    edge_n = e;
    #1;
  endtask

  task automatic cmp_path(input int l, input logic v, input logic [31:0] d,
                          input logic o, input string tag);
    int  k;
    int  e;
    bit  ev;
    bit  eo;
    k  = edge_n;
    e  = k - l + 1;
    ev = 1'b0;
    eo = 1'b0;
    if (rst_at[k]) begin
      last_d[l-1] = 32'h0;
    end else if (e >= 1 && req_v[e]) begin
      ev = 1'b1;
      for (int j = e; j < k; j++) if (rst_at[j]) ev = 1'b0;
      if (ev) begin
        eo = req_o[e];
        last_d[l-1] = req_d[e];
      end
    end
    check({tag, "_rd_valid"}, 32'(v), 32'(ev));
    check({tag, "_rd_oor"},   32'(o), 32'(eo));
    check({tag, "_rd_data"},  d, last_d[l-1]);
  endtask

  always @(negedge clk) begin
    if (edge_n > 0) begin
      cmp_path(2, v1, d1, o1, "L2");
      cmp_path(1, v0, d0, o0, "L1");
      check("L2_load_ptr",  32'(ptr1),  32'(exp_ptr[edge_n]));
      check("L1_load_ptr",  32'(ptr0),  32'(exp_ptr[edge_n]));
      check("L2_load_done", 32'(done1), 32'(exp_done[edge_n]));
      check("L1_load_done", 32'(done0), 32'(exp_done[edge_n]));
    end
  end

  task automatic drive(input bit rst, input bit we, input bit wa, input int wad,
                       input logic [31:0] wd, input bit lc, input bit re, input int ra);
    reset    = rst;
    wr_en    = we;
    wr_auto  = wa;
    wr_addr  = WA_W'(wad);
    wr_data  = wd;
    load_clr = lc;
    rd_en    = re;
    rd_addr  = 20'(ra);
    step();
  endtask

  task automatic idle();                               drive(0, 0, 0, 0, 32'h0, 0, 0, 0); endtask
  task automatic wr(input int a, input logic [31:0] d); drive(0, 1, 0, a, d, 0, 0, 0);     endtask
  task automatic awr(input logic [31:0] d, input bit lc); drive(0, 1, 1, 0, d, lc, 0, 0);  endtask
  task automatic rd(input int a);                      drive(0, 0, 0, 0, 32'h0, 0, 1, a); endtask

  initial begin
    last_d[0] = 32'h0;
    last_d[1] = 32'h0;
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    check("reset_rd_data",   d1, 32'h0);
    check("reset_rd_valid",  32'(v1), 32'h0);
    check("reset_load_ptr",  32'(ptr1), 32'h0);
    check("reset_load_done", 32'(done1), 32'h0);

    // Explicit load, then a back-to-back read stream.
    for (int k = 0; k < DEPTH; k++) wr(k, 32'hA500_0000 + 32'(k));
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      rd(4 * k);
      if (k == 0) begin
        check("lat2_not_yet_valid", 32'(v1), 32'h0);
        check("lat1_first_valid",   32'(v0), 32'h1);
        check("lat1_first_data",    d0, 32'hA500_0000);
      end
      if (k == 1) begin
        check("lat2_first_valid", 32'(v1), 32'h1);
        check("lat2_first_data",  d1, 32'hA500_0000);
        check("lat1_second_data", d0, 32'hA500_0001);
      end
    end
    idle();
    idle();
    check("stream_hold_data", d1, 32'hA500_0047);

    // Auto load with wrap.
    drive(0, 0, 0, 0, 32'h0, 1, 0, 0);
    check("clr_load_ptr", 32'(ptr1), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      awr(32'h100 + 32'(i), 1'b0);
      check("auto_load_ptr",  32'(ptr1),  32'((i + 1) % DEPTH));
      check("auto_load_done", 32'(done1), 32'(i == DEPTH - 1));
    end
    awr(32'h999, 1'b0);
    check("wrap_load_ptr",  32'(ptr1),  32'h1);
    check("wrap_load_done", 32'(done1), 32'h1);
    wr(10, 32'h1010);
    check("explicit_keeps_ptr", 32'(ptr1), 32'h1);
    wr(100, 32'hDEAD_BEEF);
    rd(0);
    rd(4 * 71);
    check("wrap_word0", d1, 32'h999);
    rd(4 * 36);
    check("auto_word71", d1, 32'h147);
    idle();
    check("word36_untouched", d1, 32'h124);
    idle();

    // Read-first collision.
    wr(5, 32'h1111_1111);
    drive(0, 1, 0, 5, 32'h2222_2222, 0, 1, 20);
    rd(20);
    check("collision_old_data", d1, 32'h1111_1111);
    check("next_read_new_data", d0, 32'h2222_2222);
    idle();
    check("next_read_new_l2", d1, 32'h2222_2222);

    // Out of range and sub-word aliasing.
    rd(288);
    rd(23);
    check("oor_valid", 32'(v1), 32'h1);
    check("oor_flag",  32'(o1), 32'h1);
    check("oor_data",  d1, 32'h0);
    check("alias_data_l1", d0, 32'h2222_2222);
    check("alias_oor_l1",  32'(o0), 32'h0);
    idle();
    check("alias_data_l2", d1, 32'h2222_2222);
    rd(20'hFFFFC);
    idle();
    idle();
    check("far_oor_hold", d1, 32'h0);

    // Reset while reads are in flight.
    rd(0);
    drive(1, 0, 0, 0, 32'h0, 0, 1, 4);
    check("midrst_valid_l2", 32'(v1), 32'h0);
    check("midrst_data_l2",  d1, 32'h0);
    check("midrst_valid_l1", 32'(v0), 32'h0);
    check("midrst_ptr",      32'(ptr1), 32'h0);
    check("midrst_done",     32'(done1), 32'h0);
    idle();
    idle();
    idle();
    rd(20);
    idle();
    check("mem_kept_after_reset", d1, 32'h2222_2222);

    // load_clr together with an auto write.
    for (int i = 0; i < DEPTH + 40; i++) awr(32'h200 + 32'(i), 1'b0);
    check("pre_clr_ptr",  32'(ptr1),  32'd40);
    check("pre_clr_done", 32'(done1), 32'h1);
    awr(32'hBEEF, 1'b1);
    check("clr_auto_ptr",  32'(ptr1),  32'h1);
    check("clr_auto_done", 32'(done1), 32'h0);
    rd(0);
    check("clr_auto_word0_l1", d0, 32'hBEEF);
    idle();
    check("clr_auto_word0_l2", d1, 32'hBEEF);
    drive(0, 0, 0, 0, 32'h0, 1, 0, 0);
    check("clr_alone_ptr", 32'(ptr1), 32'h0);
    idle();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_buffer_sdp.md
Name: bram_buffer_sdp

Overview:
- Parametrised simple-dual-port on-chip buffer for ifmap/weight words in the fused-block CNN datapath. Successor to the fixed 72x32 single-address BRAM.
- The write side is loaded by the DMA/loader, either at explicit addresses or by an auto-incrementing stream pointer.
- The read side is byte-addressed by the conv address generator and has a valid-tagged, configurable-latency pipeline.
- Reads and writes may occur in the same cycle. A write no longer blanks read data.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 72, number of words; any value from 2 to 4096.
- RD_ADDR_W, 20, width of the byte read address.
- BYTE_SHIFT, 2, right-shift from byte address to word index (log2 of bytes per word).
- OUT_REG, 1, 0 or 1; adds an output register stage (read latency = 1 + OUT_REG).
- WA_W, $clog2(DEPTH), write address width (derived localparam; not overridable).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_auto  in  1  1: write at internal load pointer, wr_addr ignored; 0: write at wr_addr
- wr_addr  in  WA_W  explicit write word address
- wr_data  in  DATA_W  write data
- load_clr  in  1  clears load pointer and load_done
- load_ptr  out  WA_W  current auto-write pointer
- load_done  out  1  sticky; set when an auto write fills word DEPTH-1
- rd_en  in  1  read request
- rd_addr  in  RD_ADDR_W  byte read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data carries the response to a request
- rd_oor  out  1  qualifies rd_valid; the request's word index was >= DEPTH

Behaviour:
- Reset (sync, high) sets rd_data=0, rd_valid=0, rd_oor=0, load_ptr=0 and load_done=0. The memory array is not cleared.
- Reset asserted mid-operation discards in-flight reads. rd_valid is 0 on the cycle after reset is sampled.
- Write path:
  - Target address = wr_auto ? load_ptr : wr_addr.
  - A write whose target address is >= DEPTH is dropped silently. It is only possible with explicit wr_addr when DEPTH is not a power of 2.
- Auto pointer:
  - Each wr_en with wr_auto=1 increments load_ptr.
  - At DEPTH-1 the pointer wraps to 0 and load_done is set in the same edge.
  - load_done stays set until load_clr or reset.
  - Explicit writes do not move load_ptr or affect load_done.
- load_clr precedence:
  - load_clr alone sets load_ptr=0 and load_done=0.
  - load_clr together with an auto write: the write lands at address 0, load_ptr becomes 1 and load_done=0.
- Read path:
  - Word index = rd_addr >> BYTE_SHIFT, with full RD_ADDR_W width kept for the range check.
  - Latency L = 1 + OUT_REG cycles from the rd_en edge to rd_valid=1.
  - Fully pipelined: one request per cycle, no stalls, no backpressure.
  - rd_valid is a delayed copy of rd_en.
- Out of range: if word index >= DEPTH, the response has rd_data=0 and rd_oor=1. The memory is not accessed.
- Idle read: rd_valid=0 and rd_oor=0; rd_data holds its last value.
- Same-cycle read and write to the same word is read-first: the response returns the old contents. The new data is visible to a read issued on the next cycle.
- Arithmetic is unsigned, with no sign extension. Bits of rd_addr below BYTE_SHIFT are ignored (sub-word offsets alias).

Decomposition:
- Package bram_pkg holds:
  - default localparams (DATA_W_DEF=32, DEPTH_DEF=72, BYTE_SHIFT_DEF=2);
  - function clog2_min1 (returns at least 1);
  - a read-latency helper rd_lat(OUT_REG).
- Sub-module bram_sdp_core holds the inferred (* ram_style="block" *) array with one write port and a registered read-first read port.
- The top level holds the load pointer, range check, valid/oor pipeline and optional output register.

Test Plan:
- Explicit load then read, DEPTH=72, OUT_REG=1: write word k = 0xA5000000+k for k=0..71, then read byte address 4*k back-to-back → rd_valid two cycles after each rd_en, rd_data=0xA5000000+k, rd_oor=0, one result per cycle.
- Auto load wrap: load_clr, then 72 auto writes of 0x100+i → load_ptr steps 0..71 then 0; load_done=1 on the edge of write 71; one further auto write goes to address 0 and leaves load_done=1.
- Collision: word 5 = 0x11111111; same cycle write 0x22222222 to 5 and read byte address 20 → response 0x11111111; read on the next cycle → 0x22222222.
- Range and alias: read byte address 288 (word 72) → rd_valid=1, rd_oor=1, rd_data=0; read byte address 23 → word 5 data, rd_oor=0.
- Reset mid-flight, OUT_REG=1: issue reads on cycles t and t+1, assert reset on t+1 → rd_valid=0 on every cycle after reset; load_ptr=0, load_done=0, memory contents preserved on a re-read.
- load_clr together with an auto write when load_ptr=40 and load_done=1 → data lands at address 0, load_ptr=1, load_done=0; OUT_REG=0 build shows latency 1.
